// File: rtl/tpu_cmd_arbiter.sv
// Round-robin arbiter sharing the TPU command-configuration port between NUM_REQ host
// requesters, with registered issue stage, completion tracking and a flush/drain barrier.
module tpu_cmd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int IDLE_GUARD = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0][31:0]          req_addr_a,
   input  logic [NUM_REQ-1:0][31:0]          req_addr_b,
   input  logic [NUM_REQ-1:0][31:0]          req_addr_c,
   input  logic [NUM_REQ-1:0][31:0]          req_addr_d,
   input  logic [NUM_REQ-1:0][7:0]           req_m,
   output logic                              cfg_valid,
   output logic [31:0]                       cfg_addr_a,
   output logic [31:0]                       cfg_addr_b,
   output logic [31:0]                       cfg_addr_c,
   output logic [31:0]                       cfg_addr_d,
   output logic [7:0]                        cfg_m,
   input  logic                              cfg_full,
   input  logic                              sys_idle,
   input  logic                              flush_req,
   output logic                              flush_done,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id,
   output logic                              job_done,
   output logic [CNT_WIDTH-1:0]              issued_cnt,
   output logic                              busy
);

   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int GUARD_W = $clog2(IDLE_GUARD + 1);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      FLUSHED
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic               grant;
   logic               pending;
   logic [GUARD_W-1:0] guard;
   logic               done_cond;

   // Search starts just past the last winner; the extra sum bit keeps the wrap exact
   // for requester counts that are not a power of two.
   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] cand;
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
         end
         cand = sum[ID_W-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Requiring cfg_valid low spaces issues two cycles apart, covering the lag of cfg_full.
   always_comb begin
      grant      = rst && (state == RUN) && !flush_req && !cfg_full && !cfg_valid && found;
      req_ready  = grant ? (NUM_REQ'(1) << winner) : '0;
      done_cond  = pending && (guard == '0) && sys_idle;
      job_done   = done_cond && !grant;
      flush_done = (state == DRAIN) && !pending && (guard == '0) && sys_idle;
      busy       = pending;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (flush_req)  state_next = DRAIN;
         DRAIN:   if (flush_done) state_next = FLUSHED;
         FLUSHED: if (!flush_req) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // A new issue outranks a same-cycle completion: pending stays set and the guard reloads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_valid  <= 1'b0;
         cfg_addr_a <= '0;
         cfg_addr_b <= '0;
         cfg_addr_c <= '0;
         cfg_addr_d <= '0;
         cfg_m      <= '0;
         grant_id   <= '0;
         issued_cnt <= '0;
         rr_ptr     <= ID_W'(NUM_REQ - 1);
         pending    <= 1'b0;
         guard      <= '0;
      end else begin
         cfg_valid <= grant;
         if (grant) begin
            cfg_addr_a <= req_addr_a[winner];
            cfg_addr_b <= req_addr_b[winner];
            cfg_addr_c <= req_addr_c[winner];
            cfg_addr_d <= req_addr_d[winner];
            cfg_m      <= req_m[winner];
            grant_id   <= winner;
            issued_cnt <= issued_cnt + CNT_WIDTH'(1);
            rr_ptr     <= winner;
            pending    <= 1'b1;
            guard      <= GUARD_W'(IDLE_GUARD);
         end else begin
            if (done_cond) begin
               pending <= 1'b0;
            end
            if (guard != '0) begin
               guard <= guard - GUARD_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tpu_cmd_arbiter.sv
// Self-checking bench for tpu_cmd_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a cycle-count based reference model.
module tb_tpu_cmd_arbiter;

   localparam int N     = 4;
   localparam int GUARD = 4;
   localparam int CW    = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N-1:0][31:0]   req_addr_a;
   logic [N-1:0][31:0]   req_addr_b;
   logic [N-1:0][31:0]   req_addr_c;
   logic [N-1:0][31:0]   req_addr_d;
   logic [N-1:0][7:0]    req_m;
   logic                 cfg_valid;
   logic [31:0]          cfg_addr_a;
   logic [31:0]          cfg_addr_b;
   logic [31:0]          cfg_addr_c;
   logic [31:0]          cfg_addr_d;
   logic [7:0]           cfg_m;
   logic                 cfg_full;
   logic                 sys_idle;
   logic                 flush_req;
   logic                 flush_done;
   logic [1:0]           grant_id;
   logic                 job_done;
   logic [CW-1:0]        issued_cnt;
   logic                 busy;

   int checks   = 0;
   int failures = 0;

   // Reference model: time is a cycle number; the guard is derived from the last issue cycle.
   int          cyc;
   int          last_issue;
   int          last_winner;
   bit          pend;
   int          mode;
   logic [31:0] exp_a, exp_b, exp_c, exp_d;
   logic [7:0]  exp_m;
   int          exp_gid;
   int          exp_cnt;
   bit          g_now;
   int          w_now;
   bit          jd_now;
   bit          fd_now;
   int          fd_count;

   always #5 clk = ~clk;

   tpu_cmd_arbiter #(.NUM_REQ(N), .IDLE_GUARD(GUARD), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr_a (req_addr_a),
      .req_addr_b (req_addr_b),
      .req_addr_c (req_addr_c),
      .req_addr_d (req_addr_d),
      .req_m      (req_m),
      .cfg_valid  (cfg_valid),
      .cfg_addr_a (cfg_addr_a),
      .cfg_addr_b (cfg_addr_b),
      .cfg_addr_c (cfg_addr_c),
      .cfg_addr_d (cfg_addr_d),
      .cfg_m      (cfg_m),
      .cfg_full   (cfg_full),
      .sys_idle   (sys_idle),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .grant_id   (grant_id),
      .job_done   (job_done),
      .issued_cnt (issued_cnt),
      .busy       (busy)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc         = 0;
      last_issue  = -1000;
      last_winner = N - 1;
      pend        = 0;
      mode        = 0;
      exp_a       = '0;
      exp_b       = '0;
      exp_c       = '0;
      exp_d       = '0;
      exp_m       = '0;
      exp_gid     = 0;
      exp_cnt     = 0;
   endtask

   function automatic bit guard_clear();
      return (cyc - last_issue) >= GUARD + 1;
   endfunction

   function automatic bit out_valid();
      return last_issue == cyc - 1;
   endfunction

   task automatic randomize_desc();
      for (int i = 0; i < N; i++) begin
         req_addr_a[i] = $urandom;
         req_addr_b[i] = $urandom;
         req_addr_c[i] = $urandom;
         req_addr_d[i] = $urandom;
         req_m[i]      = 8'($urandom);
      end
   endtask

   task automatic apply_stimulus(input logic [N-1:0] valid, input logic full,
                                 input logic idle, input logic flush);
      req_valid = valid;
      cfg_full  = full;
      sys_idle  = idle;
      flush_req = flush;
   endtask

   // Settles the inputs driven at the falling edge, then compares every output to the model.
   task automatic evaluate();
      bit found;
      #1;
      g_now = 0;
      w_now = 0;
      found = 0;
      if (mode == 0 && !flush_req && !cfg_full && !out_valid() && req_valid != '0) begin
         g_now = 1;
         for (int k = 1; k <= N; k++) begin
            if (!found && req_valid[(last_winner + k) % N]) begin
               found = 1;
               w_now = (last_winner + k) % N;
            end
         end
      end
      jd_now = pend && guard_clear() && sys_idle && !g_now;
      fd_now = (mode == 1) && !pend && guard_clear() && sys_idle;
      check_output("req_ready",  req_ready,  g_now ? (64'd1 << w_now) : 64'd0);
      check_output("job_done",   job_done,   jd_now);
      check_output("flush_done", flush_done, fd_now);
      check_output("cfg_valid",  cfg_valid,  out_valid());
      check_output("cfg_addr_a", cfg_addr_a, exp_a);
      check_output("cfg_addr_b", cfg_addr_b, exp_b);
      check_output("cfg_addr_c", cfg_addr_c, exp_c);
      check_output("cfg_addr_d", cfg_addr_d, exp_d);
      check_output("cfg_m",      cfg_m,      exp_m);
      check_output("grant_id",   grant_id,   exp_gid);
      check_output("issued_cnt", issued_cnt, exp_cnt);
      check_output("busy",       busy,       pend);
   endtask

   task automatic advance();
      if (g_now) begin
         exp_a       = req_addr_a[w_now];
         exp_b       = req_addr_b[w_now];
         exp_c       = req_addr_c[w_now];
         exp_d       = req_addr_d[w_now];
         exp_m       = req_m[w_now];
         exp_gid     = w_now;
         exp_cnt     = (exp_cnt + 1) % (1 << CW);
         last_winner = w_now;
         last_issue  = cyc;
         pend        = 1;
      end else if (jd_now) begin
         pend = 0;
      end
      case (mode)
         0:       if (flush_req) mode = 1;
         1:       if (fd_now) mode = 2;
         default: if (!flush_req) mode = 0;
      endcase
      cyc++;
      @(negedge clk);
   endtask

   task automatic tick();
      evaluate();
      advance();
   endtask

   task automatic do_reset();
      apply_stimulus('0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      rst = 1'b0;
      apply_stimulus('0, 1'b0, 1'b1, 1'b0);
      randomize_desc();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Reset state
      evaluate();
      check_output("rst_cfg_valid",  cfg_valid,  0);
      check_output("rst_issued_cnt", issued_cnt, 0);
      check_output("rst_busy",       busy,       0);
      check_output("rst_grant_id",   grant_id,   0);
      check_output("rst_cfg_m",      cfg_m,      0);
      advance();

      // Single requester
      req_m[2]      = 8'd16;
      req_addr_a[2] = 32'h100;
      apply_stimulus(4'b0100, 1'b0, 1'b1, 1'b0);
      evaluate();
      check_output("single_ready", req_ready, 4'b0100);
      advance();
      apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      evaluate();
      check_output("single_valid", cfg_valid,  1);
      check_output("single_m",     cfg_m,      16);
      check_output("single_addr",  cfg_addr_a, 32'h100);
      check_output("single_gid",   grant_id,   2);
      check_output("single_cnt",   issued_cnt, 1);
      advance();
      repeat (6) tick();

      // Round robin with all requesters held valid
      do_reset();
      apply_stimulus(4'hF, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
         evaluate();
         check_output("rr_ready", req_ready, (c % 2 == 0) ? (64'd1 << ((c / 2) % 4)) : 64'd0);
         check_output("rr_valid", cfg_valid, c % 2);
         advance();
      end

      // cfg_full blocks all grants
      cfg_full = 1'b1;
      for (int c = 0; c < 10; c++) begin
         evaluate();
         check_output("full_ready", req_ready, 0);
         check_output("full_valid", cfg_valid, 0);
         advance();
      end
      cfg_full = 1'b0;
      evaluate();
      check_output("full_release", req_ready, 4'b0010);
      advance();
      req_valid = '0;
      repeat (7) tick();

      // Completion with the idle guard
      do_reset();
      apply_stimulus(4'b0001, 1'b0, 1'b1, 1'b0);
      evaluate();
      check_output("cmp_ready", req_ready, 1);
      advance();
      req_valid = '0;
      for (int k = 1; k <= 5; k++) begin
         evaluate();
         check_output("cmp_job_done", job_done, k == 5);
         check_output("cmp_busy",     busy,     1);
         advance();
      end
      req_valid = 4'b0001;
      tick();
      for (int k = 1; k <= 8; k++) begin
         req_valid = (k == 3) ? 4'b0001 : 4'b0000;
         evaluate();
         if (k == 3) check_output("cmp2_ready", req_ready, 1);
         check_output("cmp2_job_done", job_done, k == 8);
         advance();
      end
      repeat (2) tick();

      // Flush barrier with two commands outstanding
      do_reset();
      apply_stimulus(4'hF, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      flush_req = 1'b1;
      evaluate();
      check_output("flush_block", req_ready, 0);
      advance();
      for (int c = 0; c < 5; c++) begin
         evaluate();
         check_output("flush_hold_ready", req_ready,  0);
         check_output("flush_hold_done",  flush_done, 0);
         advance();
      end
      sys_idle = 1'b1;
      fd_count = 0;
      for (int c = 0; c < 5; c++) begin
         evaluate();
         if (flush_done) fd_count++;
         advance();
      end
      check_output("flush_pulses", fd_count, 1);
      flush_req = 1'b0;
      evaluate();
      check_output("flush_exit_ready", req_ready, 0);
      advance();
      evaluate();
      check_output("flush_resume", req_ready, 4'b0100);
      advance();

      // Asynchronous reset between a grant and its cfg_valid
      do_reset();
      randomize_desc();
      apply_stimulus(4'hF, 1'b0, 1'b1, 1'b0);
      repeat (2) tick();
      evaluate();
      check_output("ar_grant", req_ready, 4'b0010);
      rst = 1'b0;
      #1;
      check_output("ar_ready",  req_ready,  0);
      check_output("ar_valid",  cfg_valid,  0);
      check_output("ar_cnt",    issued_cnt, 0);
      check_output("ar_addr_a", cfg_addr_a, 0);
      check_output("ar_busy",   busy,       0);
      @(posedge clk);
      #1;
      check_output("ar_drop", cfg_valid, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      evaluate();
      check_output("ar_first", req_ready, 4'b0001);
      advance();

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         randomize_desc();
         req_valid = N'($urandom);
         cfg_full  = ($urandom % 4) == 0;
         sys_idle  = ($urandom % 3) != 0;
         if ($urandom % 30 == 0) flush_req = ~flush_req;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
